ahb_matrix_input_stage: RTL and testbench

//  Master-side input stage of the single-slave bus matrix; sits directly upstream of the output stage.

---
 rtl/ahb_matrix_input_stage.sv | 177 +++++++++++++++++
 tb/tb_ahb_matrix_input_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_matrix_input_stage.sv
// -----------------------------------------------------------------------------
// ahb_matrix_input_stage
//
// Master-side input stage of the single-slave bus matrix. It sits directly
// upstream of the output stage and does four things:
//   * captures every address phase the master issues (HSELS & HREADYS)
//   * holds a NONSEQ/SEQ address phase that the output stage could not take
//     in the same cycle, and replays it from the hold register once granted
//   * presents either the live or the held address/control to the output
//     stage, together with held_tran_op (a real transfer is on offer)
//   * drives HREADYOUTS/HRESPS back to the master. While a transfer is
//     pending it inserts wait states. During a data phase it forwards the
//     output stage's ready and response.
// HWDATA is not stored here. It passes straight through to the output stage.
//
// Ports
//   HCLK, HRESET         clock, synchronous active-high reset
//   HSELS .. HMASTLOCKS  master address phase (select, address, control)
//   HREADYS              HREADY as seen by the master (qualifies address phase)
//   HWDATAS              master write data (passed through as wdata_op)
//   HREADYOUTS, HRESPS   ready / response back to the master
//   sel_op .. mastlock_op  muxed select + address/control to the output stage
//   wdata_op             write data to the output stage
//   held_tran_op         a valid NONSEQ/SEQ transfer is presented
//   active_op            output stage grants this port this cycle
//   HREADYMUXM, HRESPM   transfer-done / response from the output stage
// -----------------------------------------------------------------------------
module ahb_matrix_input_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic [3:0]        HMASTERS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  input  logic [DATA_W-1:0] HWDATAS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              sel_op,
  output logic [ADDR_W-1:0] addr_op,
  output logic [1:0]        trans_op,
  output logic              write_op,
  output logic [2:0]        size_op,
  output logic [2:0]        burst_op,
  output logic [3:0]        prot_op,
  output logic [3:0]        master_op,
  output logic              mastlock_op,
  output logic [DATA_W-1:0] wdata_op,
  output logic              held_tran_op,
  input  logic              active_op,
  input  logic              HREADYMUXM,
  input  logic [1:0]        HRESPM
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // One address phase worth of control. The lock flag lives in here so a
  // replayed transfer carries exactly the lock state it was issued with.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic [3:0]        master;
    logic              mastlock;
  } addr_ctl_t;

  addr_ctl_t live_ctl;
  addr_ctl_t hold_q;
  addr_ctl_t mux_ctl;

  logic pend_tran_q;
  logic pend_tran_d;
  logic data_ph_q;
  logic data_ph_d;

  logic capture;
  logic new_tran;
  logic accepted;
  logic cancel;

  always_comb begin
    live_ctl.addr     = HADDRS;
    live_ctl.trans    = HTRANSS;
    live_ctl.write    = HWRITES;
    live_ctl.size     = HSIZES;
    live_ctl.burst    = HBURSTS;
    live_ctl.prot     = HPROTS;
    live_ctl.master   = HMASTERS;
    live_ctl.mastlock = HMASTLOCKS;
  end

  // HTRANSS[1] separates NONSEQ/SEQ from IDLE/BUSY. Only the former are real
  // transfers, so only they can become pending.
  assign capture      = HSELS & HREADYS;
  assign new_tran     = capture & HTRANSS[1];
  assign held_tran_op = pend_tran_q | new_tran;
  assign accepted     = active_op & HREADYMUXM & held_tran_op;
  // The master withdrew its request: a valid address phase that is not a
  // transfer replaces the one that was waiting.
  assign cancel       = capture & ~HTRANSS[1];

  always_comb begin
    pend_tran_d = pend_tran_q;
    if (accepted) begin
      pend_tran_d = 1'b0;
    end else if (new_tran) begin
      pend_tran_d = 1'b1;
    end else if (cancel) begin
      pend_tran_d = 1'b0;
    end
  end

  always_comb begin
    data_ph_d = data_ph_q;
    if (accepted) begin
      data_ph_d = 1'b1;
    end else if (data_ph_q && HREADYMUXM) begin
      data_ph_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_q      <= '0;
      pend_tran_q <= 1'b0;
      data_ph_q   <= 1'b0;
    end else begin
      if (capture) begin
        hold_q <= live_ctl;
      end
      pend_tran_q <= pend_tran_d;
      data_ph_q   <= data_ph_d;
    end
  end

  // A pending transfer comes from the hold register. Otherwise the live
  // inputs go through with no added latency.
  assign mux_ctl = pend_tran_q ? hold_q : live_ctl;

  assign sel_op      = pend_tran_q | HSELS;
  assign addr_op     = mux_ctl.addr;
  assign trans_op    = mux_ctl.trans;
  assign write_op    = mux_ctl.write;
  assign size_op     = mux_ctl.size;
  assign burst_op    = mux_ctl.burst;
  assign prot_op     = mux_ctl.prot;
  assign master_op   = mux_ctl.master;
  assign mastlock_op = mux_ctl.mastlock;
  assign wdata_op    = HWDATAS;

  // The data phase takes priority over a pending request. The current beat
  // has to complete (or finish its two-cycle ERROR) on the slave's terms
  // before the master is stalled for the request it is still holding.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = RESP_OKAY;
    if (data_ph_q) begin
      HREADYOUTS = HREADYMUXM;
      HRESPS     = HRESPM;
    end else if (pend_tran_q) begin
      HREADYOUTS = 1'b0;
      HRESPS     = RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_ahb_matrix_input_stage.sv
module tb_ahb_matrix_input_stage;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              hsels;
  logic [ADDR_W-1:0] haddrs;
  logic [1:0]        htranss;
  logic              hwrites;
  logic [2:0]        hsizes;
  logic [2:0]        hbursts;
  logic [3:0]        hprots;
  logic [3:0]        hmasters;
  logic              hmastlocks;
  logic [DATA_W-1:0] hwdatas;
  logic              hreadyouts;
  logic [1:0]        hresps;
  logic              sel_op;
  logic [ADDR_W-1:0] addr_op;
  logic [1:0]        trans_op;
  logic              write_op;
  logic [2:0]        size_op;
  logic [2:0]        burst_op;
  logic [3:0]        prot_op;
  logic [3:0]        master_op;
  logic              mastlock_op;
  logic [DATA_W-1:0] wdata_op;
  logic              held_tran_op;
  logic              active_op;
  logic              hreadymuxm;
  logic [1:0]        hrespm;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        burst;
    logic              mastlock;
  } xfer_t;

  xfer_t sb_q[$];

  always #5 HCLK = ~HCLK;

  // Single master: its HREADY is this port's HREADYOUTS.
  ahb_matrix_input_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSELS       (hsels),
    .HADDRS      (haddrs),
    .HTRANSS     (htranss),
    .HWRITES     (hwrites),
    .HSIZES      (hsizes),
    .HBURSTS     (hbursts),
    .HPROTS      (hprots),
    .HMASTERS    (hmasters),
    .HMASTLOCKS  (hmastlocks),
    .HREADYS     (hreadyouts),
    .HWDATAS     (hwdatas),
    .HREADYOUTS  (hreadyouts),
    .HRESPS      (hresps),
    .sel_op      (sel_op),
    .addr_op     (addr_op),
    .trans_op    (trans_op),
    .write_op    (write_op),
    .size_op     (size_op),
    .burst_op    (burst_op),
    .prot_op     (prot_op),
    .master_op   (master_op),
    .mastlock_op (mastlock_op),
    .wdata_op    (wdata_op),
    .held_tran_op(held_tran_op),
    .active_op   (active_op),
    .HREADYMUXM  (hreadymuxm),
    .HRESPM      (hrespm)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_ap(input logic [ADDR_W-1:0] addr, input logic [1:0] trans,
                          input logic write, input logic [2:0] burst, input logic lock,
                          input bit push);
    hsels      = 1'b1;
    haddrs     = addr;
    htranss    = trans;
    hwrites    = write;
    hbursts    = burst;
    hmastlocks = lock;
    if (push) sb_q.push_back('{addr: addr, trans: trans, write: write, burst: burst, mastlock: lock});
  endtask

  task automatic drive_idle(input logic sel);
    hsels      = sel;
    haddrs     = '0;
    htranss    = T_IDLE;
    hwrites    = 1'b0;
    hbursts    = B_SINGLE;
    hmastlocks = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic at_sample();
    @(negedge HCLK);
  endtask

  // Scoreboard: every transfer the output stage accepts must be the next one
  // the master issued, with its address/control intact.
  always @(negedge HCLK) begin
    if (!HRESET && held_tran_op && active_op && hreadymuxm) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_accept", 64'd1, 64'd0);
      end else begin
        xfer_t e;
        e = sb_q.pop_front();
        check_val("sb_addr",     addr_op,     e.addr);
        check_val("sb_trans",    trans_op,    e.trans);
        check_val("sb_write",    write_op,    e.write);
        check_val("sb_burst",    burst_op,    e.burst);
        check_val("sb_mastlock", mastlock_op, e.mastlock);
        check_val("sb_size",     size_op,     3'b010);
        check_val("sb_sel",      sel_op,      1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    HRESET     = 1'b1;
    drive_idle(1'b0);
    hsizes     = 3'b010;
    hprots     = 4'b0011;
    hmasters   = 4'h1;
    hwdatas    = '0;
    active_op  = 1'b0;
    hreadymuxm = 1'b1;
    hrespm     = 2'b00;
    repeat (2) next_cycle();

    // Reset state
    HRESET = 1'b0;
    at_sample();
    check_val("rst_ready", hreadyouts, 1'b1);
    check_val("rst_resp",  hresps,     2'b00);
    check_val("rst_held",  held_tran_op, 1'b0);
    check_val("rst_sel",   sel_op,     1'b0);
    next_cycle();

    // 1: single write, granted immediately
    active_op = 1'b1;
    drive_ap(32'h2000_0010, T_NONSEQ, 1'b1, B_SINGLE, 1'b0, 1'b1);
    at_sample();
    check_val("s1_held_ap",  held_tran_op, 1'b1);
    check_val("s1_ready_ap", hreadyouts,   1'b1);
    next_cycle();
    drive_idle(1'b1);
    hwdatas = 32'hA5A5_0010;
    at_sample();
    check_val("s1_held_dp",  held_tran_op, 1'b0);
    check_val("s1_ready_dp", hreadyouts,   1'b1);
    check_val("s1_wdata",    wdata_op,     32'hA5A5_0010);
    next_cycle();

    // 2: held transfer, no grant for 3 cycles, then replay from hold register
    active_op = 1'b0;
    drive_ap(32'h4000_0000, T_NONSEQ, 1'b0, B_SINGLE, 1'b1, 1'b1);
    at_sample();
    check_val("s2_ready_ap", hreadyouts, 1'b1);
    next_cycle();
    drive_idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) active_op = 1'b1;
      at_sample();
      check_val("s2_ready_wait", hreadyouts,   1'b0);
      check_val("s2_addr_hold",  addr_op,      32'h4000_0000);
      check_val("s2_sel_hold",   sel_op,       1'b1);
      check_val("s2_held_hold",  held_tran_op, 1'b1);
      check_val("s2_lock_hold",  mastlock_op,  1'b1);
      next_cycle();
    end
    at_sample();
    check_val("s2_ready_dp", hreadyouts, 1'b1);
    next_cycle();

    // 3: slave inserts 2 wait states in the data phase
    drive_ap(32'h3000_0004, T_NONSEQ, 1'b1, B_SINGLE, 1'b0, 1'b1);
    at_sample();
    next_cycle();
    drive_idle(1'b1);
    hreadymuxm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_sample();
      check_val("s3_ready_wait", hreadyouts,   1'b0);
      check_val("s3_held_wait",  held_tran_op, 1'b0);
      next_cycle();
    end
    hreadymuxm = 1'b1;
    at_sample();
    check_val("s3_ready_done", hreadyouts, 1'b1);
    next_cycle();

    // 4: two-cycle ERROR response
    drive_ap(32'h3000_0008, T_NONSEQ, 1'b0, B_SINGLE, 1'b0, 1'b1);
    at_sample();
    next_cycle();
    drive_idle(1'b1);
    hreadymuxm = 1'b0;
    hrespm     = 2'b01;
    at_sample();
    check_val("s4_resp_c1",  hresps,     2'b01);
    check_val("s4_ready_c1", hreadyouts, 1'b0);
    next_cycle();
    hreadymuxm = 1'b1;
    at_sample();
    check_val("s4_resp_c2",  hresps,     2'b01);
    check_val("s4_ready_c2", hreadyouts, 1'b1);
    next_cycle();
    hrespm = 2'b00;
    at_sample();
    check_val("s4_resp_after",  hresps,     2'b00);
    check_val("s4_ready_after", hreadyouts, 1'b1);
    next_cycle();

    // 5: INCR4 burst, grant lost on beat 3 which is held and replayed
    drive_ap(32'h5000_0000, T_NONSEQ, 1'b1, B_INCR4, 1'b0, 1'b1);
    at_sample();
    next_cycle();
    drive_ap(32'h5000_0004, T_SEQ, 1'b1, B_INCR4, 1'b0, 1'b1);
    at_sample();
    check_val("s5_ready_b2", hreadyouts, 1'b1);
    next_cycle();
    active_op = 1'b0;
    drive_ap(32'h5000_0008, T_SEQ, 1'b1, B_INCR4, 1'b0, 1'b1);
    at_sample();
    check_val("s5_ready_b3", hreadyouts, 1'b1);
    next_cycle();
    drive_ap(32'h5000_000C, T_SEQ, 1'b1, B_INCR4, 1'b0, 1'b1);
    at_sample();
    check_val("s5_ready_hold", hreadyouts, 1'b0);
    check_val("s5_addr_hold",  addr_op,    32'h5000_0008);
    check_val("s5_trans_hold", trans_op,   T_SEQ);
    check_val("s5_burst_hold", burst_op,   B_INCR4);
    next_cycle();
    active_op = 1'b1;
    at_sample();
    check_val("s5_ready_grant", hreadyouts, 1'b0);
    check_val("s5_addr_grant",  addr_op,    32'h5000_0008);
    next_cycle();
    at_sample();
    check_val("s5_ready_b4", hreadyouts, 1'b1);
    check_val("s5_addr_b4",  addr_op,    32'h5000_000C);
    next_cycle();
    drive_idle(1'b1);
    at_sample();
    check_val("s5_ready_end", hreadyouts, 1'b1);
    next_cycle();
    check_val("s5_sb_drained", sb_q.size(), 0);

    // 7: BUSY is never held
    active_op = 1'b0;
    drive_ap(32'h7000_0000, T_BUSY, 1'b0, B_INCR4, 1'b0, 1'b0);
    at_sample();
    check_val("s7_held_busy", held_tran_op, 1'b0);
    next_cycle();
    drive_idle(1'b0);
    at_sample();
    check_val("s7_ready_busy", hreadyouts, 1'b1);
    next_cycle();

    // 6: reset while a transfer is pending drops it with no replay
    drive_ap(32'h6000_0000, T_NONSEQ, 1'b1, B_SINGLE, 1'b0, 1'b0);
    at_sample();
    next_cycle();
    drive_idle(1'b0);
    at_sample();
    check_val("s6_ready_pend", hreadyouts, 1'b0);
    HRESET = 1'b1;
    next_cycle();
    HRESET    = 1'b0;
    active_op = 1'b1;
    at_sample();
    check_val("s6_ready_rst", hreadyouts,   1'b1);
    check_val("s6_held_rst",  held_tran_op, 1'b0);
    check_val("s6_sel_rst",   sel_op,       1'b0);
    next_cycle();
    at_sample();
    check_val("s6_held_later", held_tran_op, 1'b0);
    next_cycle();
    check_val("s6_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
